// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage definitions: RV32I NOP encoding, instruction width and
// default fetch address width / reset PC. The decoder and the IF/ID flush
// logic import the same constants so that every stage agrees on what a bubble is.
package fetch_queue_pkg;

  localparam int               INSTR_WIDTH      = 32;
  localparam logic [31:0]      NOP_INSTR        = 32'h0000_0013;
  localparam int               DEFAULT_ADDR_W   = 9;
  localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH entries of {pc, instruction}.
// One synchronous write port and one asynchronous read port, so the head
// entry is visible in the same cycle the read pointer selects it.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn_i,
  input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]         wrData_i,
  input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
  output logic [WIDTH-1:0]         rdData_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Clear every slot on reset so no stale entry can ever leak out; otherwise write on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, addresses the combinational
// instruction ROM and buffers {pc, instruction} pairs for the IF/ID register.
// A redirect flushes the whole queue in one cycle and restarts fetch.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty the ROM
// output is presented at the head directly (0-cycle fetch-to-dequeue latency).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = INSTR_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [INSTR_W-1:0]     rom_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [INSTR_W-1:0]     deq_instr,
  output logic [ADDR_W-1:0]      deq_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               queueEmpty;
  logic               queueFull;
  logic               queueDeq;
  logic               enq;
  logic               pcAdvance;
  logic               bypassHit;
  logic               bypassTaken;
  logic [ENTRY_W-1:0] headEntry;
  logic [ENTRY_W-1:0] wrEntry;

  assign queueEmpty = (count_q == '0);
  assign queueFull  = (count_q == CNT_W'(DEPTH));
  assign rom_addr   = fetchPc_q;
  assign count      = count_q;
  assign wrEntry    = {fetchPc_q, rom_data};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (enq),
    .wrAddr_i (wrPtr_q),
    .wrData_i (wrEntry),
    .rdAddr_i (rdPtr_q),
    .rdData_o (headEntry)
  );

  // Handshake decisions: a redirect blocks every dequeue and enqueue; a full
  // queue can still accept when its head leaves in the same cycle; a bypassed
  // word that is consumed directly never needs a queue slot.
  always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
    bypassHit   = reset && !redirect && queueEmpty;
    bypassTaken = bypassHit && deq_ready;
`else
    bypassHit   = 1'b0;
    bypassTaken = 1'b0;
`endif
    queueDeq  = !redirect && !queueEmpty && deq_ready;
    enq       = !redirect && (!queueFull || queueDeq) && !bypassTaken;
    pcAdvance = enq || bypassTaken;
  end

  // Head presentation: bypassed ROM word, queued head, or a NOP bubble with PC 0.
  always_comb begin
    deq_valid = 1'b0;
    deq_instr = INSTR_W'(NOP_INSTR);
    deq_pc    = '0;
    if (bypassHit) begin
      deq_valid = 1'b1;
      deq_instr = rom_data;
      deq_pc    = fetchPc_q;
    end else if (!redirect && !queueEmpty) begin
      deq_valid = 1'b1;
      {deq_pc, deq_instr} = headEntry;
    end
  end

  // Next-state for pointers, occupancy and fetch PC; a redirect wipes the queue
  // and loads a word-aligned restart address.
  always_comb begin
    fetchPc_d = fetchPc_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    if (redirect) begin
      fetchPc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
    end else begin
      if (enq) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (queueDeq) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      if (pcAdvance) begin
        fetchPc_d = fetchPc_q + ADDR_W'(4);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(queueDeq);
    end
  end

  // State registers; reset discards the queue immediately and restarts fetch at RESET_PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc_q <= RESET_PC;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// redirect / back-pressure traffic, all compared against a queue-based model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [8:0]  romAddr;
  logic [31:0] romData;
  logic        redirect;
  logic [8:0]  redirectPc;
  logic        deqReady;
  logic        deqValid;
  logic [31:0] deqInstr;
  logic [8:0]  deqPc;
  logic [2:0]  count;

  int          checkCount = 0;
  int          errorCount = 0;

  entry_t      modelQ[$];
  logic [8:0]  modelPc;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (romAddr),
    .rom_data    (romData),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .deq_ready   (deqReady),
    .deq_valid   (deqValid),
    .deq_instr   (deqInstr),
    .deq_pc      (deqPc),
    .count       (count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct pseudo-random word per ROM address.
  function automatic logic [31:0] romWord(input logic [8:0] a);
    logic [31:0] x;
    x = {23'd0, a} * 32'h9E37_79B1;
    return x ^ {a, 23'h15A5A5};
  endfunction

  assign romData = romWord(romAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model at the edge.
  task automatic applyStimulus(input logic redir, input logic [8:0] rpc, input logic ready);
    logic        expValid;
    logic [8:0]  expPc;
    logic [31:0] expInstr;
    logic        useBypass;
    logic        doDeq;
    logic        doEnq;
    entry_t      e;
    @(negedge clk);
    redirect   = redir;
    redirectPc = rpc;
    deqReady   = ready;
    #1;
    useBypass = BYPASS && !redir && (modelQ.size() == 0);
    expValid  = 1'b0;
    expPc     = '0;
    expInstr  = NOP;
    if (useBypass) begin
      expValid = 1'b1;
      expPc    = modelPc;
      expInstr = romWord(modelPc);
    end else if (!redir && modelQ.size() > 0) begin
      expValid = 1'b1;
      expPc    = modelQ[0].pc;
      expInstr = modelQ[0].instr;
    end
    checkOutput("rom_addr", 32'(romAddr), 32'(modelPc));
    checkOutput("count", 32'(count), 32'(modelQ.size()));
    checkOutput("deq_valid", 32'(deqValid), 32'(expValid));
    checkOutput("deq_pc", 32'(deqPc), 32'(expPc));
    checkOutput("deq_instr", deqInstr, expInstr);
    if (redir) begin
      modelQ.delete();
      modelPc = rpc & 9'h1FC;
    end else if (useBypass) begin
      if (!ready) begin
        e.pc = modelPc;
        e.instr = romWord(modelPc);
        modelQ.push_back(e);
      end
      modelPc = modelPc + 9'd4;
    end else begin
      doDeq = (modelQ.size() > 0) && ready;
      doEnq = (modelQ.size() < DEPTH) || doDeq;
      if (doDeq) void'(modelQ.pop_front());
      if (doEnq) begin
        e.pc = modelPc;
        e.instr = romWord(modelPc);
        modelQ.push_back(e);
        modelPc = modelPc + 9'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously between edges, check the cleared outputs at once, then release.
  task automatic applyReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(deqValid), 32'd0);
    checkOutput("rst_instr", deqInstr, NOP);
    checkOutput("rst_pc", 32'(deqPc), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_rom_addr", 32'(romAddr), 32'd0);
    modelQ.delete();
    modelPc = '0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    deqReady   = 1'b0;
    modelPc    = '0;

    // Reset then free-flowing fetch.
    applyReset();
    @(negedge clk);
    #1;
    checkOutput("first_valid", 32'(deqValid), 32'(BYPASS));
    @(posedge clk);
    #1;
    modelQ.delete();
    modelPc = '0;
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);

    // Back-pressure from a fresh start: queue fills and fetch holds at 16.
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_rom_addr", 32'(romAddr), 32'h10);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);

    // Full queue draining and refilling every cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("steady_count", 32'(count), 32'd4);

    // Redirect with three entries queued.
    applyStimulus(1'b1, 9'h000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_redir_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 9'h0A3, 1'b1);
    checkOutput("post_redir_count", 32'(count), 32'd0);
    checkOutput("post_redir_rom_addr", 32'(romAddr), 32'h0A0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);

    // Back-to-back redirects: the later target wins.
    applyStimulus(1'b1, 9'h040, 1'b1);
    applyStimulus(1'b1, 9'h080, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);

    // Fetch PC wrap-around.
    applyStimulus(1'b1, 9'h1F9, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, i[0]);

    // Reset mid-stream with two queued entries.
    applyStimulus(1'b1, 9'h100, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_reset_count", 32'(count), 32'd2);
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);

    // Random redirects and back-pressure.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 9'($urandom), ($urandom_range(0, 3) != 0) ^ (i[6]));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
